// File: rtl/fdiv_operand_queue.sv
// Operand issue queue ahead of fdiv: DEPTH-entry FIFO that classifies each (a, b) pair at enqueue.
// Latency: push-to-head 1 cycle, no bypass. Backpressure: in_ready low only when full, independent of out_ready.
module fdiv_operand_queue #(
  parameter int N     = 32,
  parameter int DEPTH = 4,
  localparam int EXP_LEN = (N == 64) ? 11 : 8,
  localparam int MAN_LEN = (N == 64) ? 52 : 23,
  localparam int BIAS    = (1 << (EXP_LEN - 1)) - 1,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N-1:0]              in_a,
  input  logic [N-1:0]              in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N-1:0]              out_a,
  output logic [N-1:0]              out_b,
  output logic                      out_sign,
  output logic [2:0]                out_cls,
  output logic signed [EXP_LEN+1:0] out_ediff,
  output logic [CW-1:0]             count
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = EXP_LEN + 2;
  localparam logic [CW-1:0]        FULL    = CW'(DEPTH);
  localparam logic signed [EW-1:0] OVF_LIM = EW'(BIAS);
  localparam logic signed [EW-1:0] UNF_LIM = EW'(1 - BIAS);

  localparam logic [2:0] CLS_NORM = 3'd0;
  localparam logic [2:0] CLS_ZERO = 3'd1;
  localparam logic [2:0] CLS_OVF  = 3'd2;
  localparam logic [2:0] CLS_UNF  = 3'd3;
  localparam logic [2:0] CLS_INF  = 3'd4;
  localparam logic [2:0] CLS_NAN  = 3'd5;

  typedef struct packed {
    logic [N-1:0]         a;
    logic [N-1:0]         b;
    logic                 sign;
    logic [2:0]           cls;
    logic signed [EW-1:0] ediff;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        new_ent;
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop;

  logic [EXP_LEN-1:0] ea, eb;
  logic [MAN_LEN-1:0] ma, mb;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign ea = in_a[N-2 -: EXP_LEN];
  assign eb = in_b[N-2 -: EXP_LEN];
  assign ma = in_a[MAN_LEN-1:0];
  assign mb = in_b[MAN_LEN-1:0];

  // Denormals flush to zero: an all-zero exponent means zero regardless of mantissa.
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (ma == '0);
  assign b_inf  = (eb == '1) && (mb == '0);
  assign a_nan  = (ea == '1) && (ma != '0);
  assign b_nan  = (eb == '1) && (mb != '0);

  always_comb begin
    new_ent       = '0;
    new_ent.a     = in_a;
    new_ent.b     = in_b;
    new_ent.sign  = in_a[N-1] ^ in_b[N-1];
    new_ent.ediff = {2'b00, ea} - {2'b00, eb};
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      new_ent.cls = CLS_NAN;
    else if (a_inf || (b_zero && !a_zero))
      new_ent.cls = CLS_INF;
    else if (a_zero || b_inf)
      new_ent.cls = CLS_ZERO;
    else if (new_ent.ediff > OVF_LIM)
      new_ent.cls = CLS_OVF;
    else if (new_ent.ediff < UNF_LIM)
      new_ent.cls = CLS_UNF;
    else
      new_ent.cls = CLS_NORM;
  end

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= new_ent;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head is masked while empty so reset and drained states present all-zero outputs.
  assign head      = mem[rd_ptr];
  assign out_a     = out_valid ? head.a     : '0;
  assign out_b     = out_valid ? head.b     : '0;
  assign out_sign  = out_valid ? head.sign  : 1'b0;
  assign out_cls   = out_valid ? head.cls   : 3'd0;
  assign out_ediff = out_valid ? head.ediff : '0;
  assign count     = count_q;

endmodule

// File: tb/tb_fdiv_operand_queue.sv
// Directed + random bench for fdiv_operand_queue: a scoreboard queue models FIFO contents and
// every cycle's handshake/head outputs; a second instance covers the 64-bit format.
module tb_fdiv_operand_queue;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, out_sign;
  logic [31:0] in_a, in_b, out_a, out_b;
  logic [2:0]  out_cls, count;
  logic [9:0]  out_ediff;

  logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_out_sign;
  logic [63:0] d_in_a, d_in_b, d_out_a, d_out_b;
  logic [2:0]  d_out_cls, d_count;
  logic [12:0] d_out_ediff;

  fdiv_operand_queue #(.N(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_sign(out_sign), .out_cls(out_cls), .out_ediff(out_ediff), .count(count)
  );

  fdiv_operand_queue #(.N(64), .DEPTH(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_a(d_in_a), .in_b(d_in_b),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_a(d_out_a), .out_b(d_out_b),
    .out_sign(d_out_sign), .out_cls(d_out_cls), .out_ediff(d_out_ediff), .count(d_count)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sign;
    logic [2:0]  cls;
    int          ediff;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t ref_model(input logic [63:0] a, input logic [63:0] b, input bit dbl);
    exp_t e;
    int el, ml, emax, bias, ea, eb, d;
    bit ma_nz, mb_nz, an, bn, ai, bi, az, bz;
    el    = dbl ? 11 : 8;
    ml    = dbl ? 52 : 23;
    emax  = (1 << el) - 1;
    bias  = (1 << (el - 1)) - 1;
    ea    = int'((a >> ml) & 64'(emax));
    eb    = int'((b >> ml) & 64'(emax));
    ma_nz = (a & ((64'd1 << ml) - 64'd1)) != 64'd0;
    mb_nz = (b & ((64'd1 << ml) - 64'd1)) != 64'd0;
    an = (ea == emax) && ma_nz;  bn = (eb == emax) && mb_nz;
    ai = (ea == emax) && !ma_nz; bi = (eb == emax) && !mb_nz;
    az = (ea == 0);              bz = (eb == 0);
    d  = ea - eb;
    e.a = a;
    e.b = b;
    e.sign  = dbl ? (a[63] ^ b[63]) : (a[31] ^ b[31]);
    e.ediff = d;
    if (an || bn || (az && bz) || (ai && bi)) e.cls = 3'd5;
    else if (ai || (bz && !az))               e.cls = 3'd4;
    else if (az || bi)                        e.cls = 3'd1;
    else if (d > bias)                        e.cls = 3'd2;
    else if (d < 1 - bias)                    e.cls = 3'd3;
    else                                      e.cls = 3'd0;
    return e;
  endfunction

  function automatic logic [31:0] rand_fp();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h7F80_0000;
      2:       return 32'h7FC0_0001;
      3:       return 32'h0000_0123;
      default: return $urandom;
    endcase
  endfunction

  // Checks state against the model at negedge, then applies this cycle's handshakes to the model.
  task automatic step(output bit pushed);
    exp_t h;
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    chk("count", 64'(count), 64'(sb.size()));
    chk("in_ready", 64'(in_ready), 64'(sb.size() != 4));
    if (sb.size() != 0) begin
      h = sb[0];
      chk("head_a", 64'(out_a), h.a);
      chk("head_b", 64'(out_b), h.b);
      chk("head_sign", 64'(out_sign), 64'(h.sign));
      chk("head_cls", 64'(out_cls), 64'(h.cls));
      chk("head_ediff", 64'($signed(out_ediff)), 64'(h.ediff));
    end
    pushed = in_valid && (sb.size() != 4);
    if (out_ready && sb.size() != 0) void'(sb.pop_front());
    if (pushed) sb.push_back(ref_model(64'(in_a), 64'(in_b), 1'b0));
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bit p;
    step(p);
  endtask

  task automatic t_cls(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] cls, input int ediff, input logic sign);
    in_a = a; in_b = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_cls"}, 64'(out_cls), 64'(cls));
    chk({tag, "_ediff"}, 64'($signed(out_ediff)), 64'(ediff));
    chk({tag, "_sign"}, 64'(out_sign), 64'(sign));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit p;
    int sent, cyc;
    logic [31:0] pa, pb;
    exp_t e;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    d_in_valid = 1'b0; d_out_ready = 1'b0; d_in_a = '0; d_in_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_a", 64'(out_a), 64'd0);
    rst_n = 1'b1;

    // Single transaction: 3.0 / 1.0
    in_a = 32'h4040_0000; in_b = 32'h3F80_0000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_cls", 64'(out_cls), 64'd0);
    chk("t1_sign", 64'(out_sign), 64'd0);
    chk("t1_ediff", 64'($signed(out_ediff)), 64'd1);
    chk("t1_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t1_empty_valid", 64'(out_valid), 64'd0);
    chk("t1_empty_count", 64'(count), 64'd0);

    // Fill, refuse when full even while popping, then drain in order
    for (int i = 0; i < 4; i++) begin
      in_a = 32'h3F80_0000 + 32'(i); in_b = 32'h4000_0000; in_valid = 1'b1;
      tick();
    end
    chk("t2_full_ready", 64'(in_ready), 64'd0);
    chk("t2_full_count", 64'(count), 64'd4);
    in_a = 32'h4100_0000; in_b = 32'h3F80_0000;
    tick();
    chk("t2_held_count", 64'(count), 64'd4);
    out_ready = 1'b1;
    tick();
    chk("t2_popfull_count", 64'(count), 64'd3);
    tick();
    chk("t2_pushpop_count", 64'(count), 64'd3);
    in_valid = 1'b0;
    repeat (4) tick();
    out_ready = 1'b0;
    chk("t2_drained", 64'(count), 64'd0);

    // Classification table
    t_cls("c_0div0", 32'h0000_0000, 32'h0000_0000, 3'd5, 0, 1'b0);
    t_cls("c_1divm0", 32'h3F80_0000, 32'h8000_0000, 3'd4, 127, 1'b1);
    t_cls("c_0div5", 32'h0000_0000, 32'h40A0_0000, 3'd1, -129, 1'b0);
    t_cls("c_ovf", 32'h7F00_0000, 32'h0080_0000, 3'd2, 253, 1'b0);
    t_cls("c_unf", 32'h0080_0000, 32'h7F00_0000, 3'd3, -253, 1'b0);
    t_cls("c_nan", 32'h7FC0_0000, 32'h3F80_0000, 3'd5, 128, 1'b0);
    t_cls("c_denorm_b", 32'h3F80_0000, 32'h0000_0001, 3'd4, 127, 1'b0);

    // Random stream with random source/sink stalls
    sent = 0; cyc = 0;
    pa = rand_fp(); pb = rand_fp();
    while (sent < 100 && cyc < 3000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = pa; in_b = pb;
      out_ready = ($urandom_range(0, 2) != 0);
      step(p);
      cyc++;
      if (p) begin
        sent++;
        pa = rand_fp(); pb = rand_fp();
      end
    end
    chk("t4_sent", 64'(sent), 64'd100);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) tick();
    out_ready = 1'b0;
    chk("t4_count", 64'(count), 64'd0);

    // Reset with entries held
    for (int i = 0; i < 3; i++) begin
      in_a = 32'h4000_0000 + 32'(i); in_b = 32'h3F80_0000; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("t5_pre_count", 64'(count), 64'd3);
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_valid", 64'(out_valid), 64'd0);
    chk("t5_ready", 64'(in_ready), 64'd1);
    chk("t5_a", 64'(out_a), 64'd0);
    chk("t5_b", 64'(out_b), 64'd0);
    chk("t5_sign", 64'(out_sign), 64'd0);
    chk("t5_cls", 64'(out_cls), 64'd0);
    chk("t5_ediff", 64'(out_ediff), 64'd0);
    rst_n = 1'b1;
    sb.delete();
    in_a = 32'hC040_0000; in_b = 32'h3F80_0000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t5_post_a", 64'(out_a), 64'hC040_0000);
    chk("t5_post_sign", 64'(out_sign), 64'd1);
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    chk("t5_post_count", 64'(count), 64'd0);

    // 64-bit format
    d_in_a = 64'h4000_0000_0000_0000; d_in_b = 64'h3FF0_0000_0000_0000; d_in_valid = 1'b1;
    @(posedge clk);
    #1;
    d_in_valid = 1'b0;
    e = ref_model(64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b1);
    chk("d_valid", 64'(d_out_valid), 64'd1);
    chk("d_cls", 64'(d_out_cls), 64'd0);
    chk("d_cls_model", 64'(d_out_cls), 64'(e.cls));
    chk("d_ediff", 64'($signed(d_out_ediff)), 64'd1);
    chk("d_a", d_out_a, 64'h4000_0000_0000_0000);
    d_out_ready = 1'b1;
    @(posedge clk);
    #1;
    d_out_ready = 1'b0;
    chk("d_count0", 64'(d_count), 64'd0);
    d_in_a = 64'h3FF0_0000_0000_0000; d_in_b = 64'h0000_0000_0000_0001; d_in_valid = 1'b1;
    @(posedge clk);
    #1;
    d_in_valid = 1'b0;
    chk("d_denorm_cls", 64'(d_out_cls), 64'd4);
    chk("d_denorm_ediff", 64'($signed(d_out_ediff)), 64'd1023);
    chk("d_count1", 64'(d_count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
